// File: rtl/time_counter_bcd.sv
// 24-hour HH:MM:SS time-of-day counter in BCD with a 1 Hz prescaler and a
// RUN/SET mode in which time is frozen and hours/minutes can be stepped.
module time_counter_bcd #(
  parameter int TICK_DIV = 100_000_000,
  parameter int CNT_W    = 27
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       set_en,
  input  logic       inc_min,
  input  logic       inc_hr,
  output logic [3:0] h1,
  output logic [3:0] h0,
  output logic [3:0] m1,
  output logic [3:0] m0,
  output logic [3:0] s1,
  output logic [3:0] s0,
  output logic       tick_1hz,
  output logic       day_wrap,
  output logic       setting
);

  typedef enum logic {RUN_S = 1'b0, SET_S = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       h1_q, h1_d, h0_q, h0_d, m1_q, m1_d, m0_q, m0_d, s1_q, s1_d, s0_q, s0_d;
  logic             tick_q, tick_d, wrap_q, wrap_d;

  logic             term;
  logic             s_c, m_c, h_c;
  logic [3:0]       s1_i, s0_i, m1_i, m0_i, h1_i, h0_i;

  // Returns {carry, tens, units} for a BCD pair counting 00..59.
  function automatic logic [8:0] inc60(input logic [3:0] t, input logic [3:0] o);
    if (o == 4'd9) begin
      if (t == 4'd5) return {1'b1, 4'd0, 4'd0};
      else           return {1'b0, t + 4'd1, 4'd0};
    end
    return {1'b0, t, o + 4'd1};
  endfunction

  // Returns {carry, tens, units} for a BCD pair counting 00..23.
  function automatic logic [8:0] inc24(input logic [3:0] t, input logic [3:0] o);
    if (t == 4'd2 && o == 4'd3) return {1'b1, 4'd0, 4'd0};
    if (o == 4'd9)              return {1'b0, t + 4'd1, 4'd0};
    return {1'b0, t, o + 4'd1};
  endfunction

  always_comb begin
    term = (cnt_q == CNT_W'(TICK_DIV - 1));
    {s_c, s1_i, s0_i} = inc60(s1_q, s0_q);
    {m_c, m1_i, m0_i} = inc60(m1_q, m0_q);
    {h_c, h1_i, h0_i} = inc24(h1_q, h0_q);

    state_d = state_q;
    cnt_d   = cnt_q;
    h1_d = h1_q; h0_d = h0_q; m1_d = m1_q; m0_d = m0_q; s1_d = s1_q; s0_d = s0_q;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;

    case (state_q)
      RUN_S: begin
        if (set_en) begin
          // Entering SET freezes time; a coincident terminal count is dropped.
          state_d = SET_S;
          cnt_d   = '0;
        end else if (term) begin
          cnt_d  = '0;
          tick_d = 1'b1;
          s1_d = s1_i; s0_d = s0_i;
          if (s_c) begin
            m1_d = m1_i; m0_d = m0_i;
          end
          if (s_c && m_c) begin
            h1_d = h1_i; h0_d = h0_i;
          end
          wrap_d = s_c && m_c && h_c;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SET_S: begin
        cnt_d = '0;
        if (inc_min) begin
          m1_d = m1_i; m0_d = m0_i;
        end
        if (inc_hr) begin
          h1_d = h1_i; h0_d = h0_i;
        end
        if (!set_en) begin
          state_d = RUN_S;
          s1_d = 4'd0; s0_d = 4'd0;
        end
      end
      default: state_d = RUN_S;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN_S;
      cnt_q   <= '0;
      h1_q <= 4'd0; h0_q <= 4'd0; m1_q <= 4'd0; m0_q <= 4'd0; s1_q <= 4'd0; s0_q <= 4'd0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      h1_q <= h1_d; h0_q <= h0_d; m1_q <= m1_d; m0_q <= m0_d; s1_q <= s1_d; s0_q <= s0_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
    end
  end

  assign h1 = h1_q;
  assign h0 = h0_q;
  assign m1 = m1_q;
  assign m0 = m0_q;
  assign s1 = s1_q;
  assign s0 = s0_q;
  assign tick_1hz = tick_q;
  assign day_wrap = wrap_q;
  assign setting  = (state_q == SET_S);

endmodule

// File: tb/tb_time_counter_bcd.sv
// Bench for time_counter_bcd: seconds-of-day reference model checked every
// cycle, directed scenarios pinned with literal values, then random stimulus.
module tb_time_counter_bcd;
  localparam int TD = 4;

  logic clk, rst_n, set_en, inc_min, inc_hr;
  logic [3:0] h1, h0, m1, m0, s1, s0;
  logic tick_1hz, day_wrap, setting;

  int n_chk = 0;
  int n_err = 0;
  bit cmp_en = 0;

  time_counter_bcd #(.TICK_DIV(TD), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .set_en(set_en), .inc_min(inc_min), .inc_hr(inc_hr),
    .h1(h1), .h0(h0), .m1(m1), .m0(m0), .s1(s1), .s0(s0),
    .tick_1hz(tick_1hz), .day_wrap(day_wrap), .setting(setting)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int tod;
    bit st;
    int cnt;
    bit tick;
    bit wrap;
  } m_t;

  m_t mdl = '{tod: 0, st: 0, cnt: 0, tick: 0, wrap: 0};

  function automatic m_t step(m_t c, bit se, bit im, bit ih);
    m_t n;
    int h, m, s;
    n = c;
    n.tick = 0;
    n.wrap = 0;
    if (!c.st) begin
      if (se) begin
        n.st = 1;
        n.cnt = 0;
      end else if (c.cnt == TD - 1) begin
        n.cnt = 0;
        n.tick = 1;
        n.tod = (c.tod + 1) % 86400;
        n.wrap = (n.tod == 0);
      end else begin
        n.cnt = c.cnt + 1;
      end
    end else begin
      h = c.tod / 3600;
      m = (c.tod / 60) % 60;
      s = c.tod % 60;
      if (im) m = (m + 1) % 60;
      if (ih) h = (h + 1) % 24;
      n.cnt = 0;
      if (!se) begin
        s = 0;
        n.st = 0;
      end
      n.tod = h * 3600 + m * 60 + s;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mdl <= '{tod: 0, st: 0, cnt: 0, tick: 0, wrap: 0};
    else        mdl <= step(mdl, set_en, inc_min, inc_hr);
  end

  function automatic logic [26:0] exp_vec(m_t c);
    int h, m, s;
    h = c.tod / 3600;
    m = (c.tod / 60) % 60;
    s = c.tod % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10),
            c.tick, c.wrap, c.st};
  endfunction

  wire [26:0] dut_vec = {h1, h0, m1, m0, s1, s0, tick_1hz, day_wrap, setting};

  always @(negedge clk) begin
    if (cmp_en) begin
      n_chk++;
      if (dut_vec !== exp_vec(mdl)) begin
        n_err++;
        $display("FAIL model t=%0t got %h%h:%h%h:%h%h tick=%b wrap=%b set=%b want %h tick/wrap/set=%b",
                 $time, h1, h0, m1, m0, s1, s0, tick_1hz, day_wrap, setting,
                 exp_vec(mdl)[26:3], exp_vec(mdl)[2:0]);
      end
    end
  end

  task automatic chk(input string nm, input int got, input int want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got %0d want %0d", nm, got, want);
    end
  endtask

  function automatic int hh();  return h1 * 10 + h0; endfunction
  function automatic int mm();  return m1 * 10 + m0; endfunction
  function automatic int ss();  return s1 * 10 + s0; endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic hold_inc(input bit is_hr, input int n);
    if (n > 0) begin
      if (is_hr) inc_hr = 1; else inc_min = 1;
      cyc(n);
      inc_hr = 0;
      inc_min = 0;
    end
  endtask

  initial begin
    rst_n = 0; set_en = 0; inc_min = 0; inc_hr = 0;
    cyc(2);
    cmp_en = 1;
    chk("reset_time", hh() * 10000 + mm() * 100 + ss(), 0);
    chk("reset_flags", {tick_1hz, day_wrap, setting}, 0);
    rst_n = 1;

    cyc(4);
    chk("first_tick", tick_1hz, 1);
    chk("first_s0", s0, 1);
    cyc(8);
    chk("sec_03", ss(), 3);

    // 09:59 via SET, then roll to 10:00:00
    set_en = 1; cyc(1);
    hold_inc(1, 9); hold_inc(0, 59);
    chk("set_0959", hh() * 100 + mm(), 959);
    set_en = 0; cyc(1 + 59 * TD);
    chk("t_095959", hh() * 10000 + mm() * 100 + ss(), 95959);
    cyc(TD);
    chk("t_100000", hh() * 10000 + mm() * 100 + ss(), 100000);
    chk("no_wrap_10", day_wrap, 0);

    // 23:59:59 -> 00:00:00 with single-cycle day_wrap
    set_en = 1; cyc(1);
    hold_inc(1, 13); hold_inc(0, 59);
    set_en = 0; cyc(1 + 59 * TD);
    chk("t_235959", hh() * 10000 + mm() * 100 + ss(), 235959);
    cyc(TD);
    chk("t_midnight", hh() * 10000 + mm() * 100 + ss(), 0);
    chk("wrap_hi", day_wrap, 1);
    cyc(1);
    chk("wrap_lo", day_wrap, 0);

    // SET stepping boundaries
    set_en = 1; cyc(1);
    chk("setting_hi", setting, 1);
    hold_inc(0, 59);
    hold_inc(0, 1);
    chk("min_wrap", hh() * 100 + mm(), 0);
    hold_inc(1, 23);
    chk("hr_23", hh(), 23);
    hold_inc(1, 1);
    chk("hr_wrap", hh(), 0);
    chk("set_no_wrap", day_wrap, 0);
    hold_inc(1, 12); hold_inc(0, 30);
    inc_min = 1; inc_hr = 1; cyc(1); inc_min = 0; inc_hr = 0;
    chk("both_inc", hh() * 100 + mm(), 1331);
    set_en = 0; cyc(2);
    inc_min = 1; inc_hr = 1; cyc(1); inc_min = 0; inc_hr = 0;
    chk("run_ignores_inc", hh() * 100 + mm(), 1331);

    // Reach 17:42:15, enter SET, reset mid-cycle
    set_en = 1; cyc(1);
    hold_inc(1, 4); hold_inc(0, 11);
    set_en = 0; cyc(1 + 15 * TD);
    chk("t_174215", hh() * 10000 + mm() * 100 + ss(), 174215);
    set_en = 1; cyc(2);
    #2 rst_n = 0;
    #1;
    chk("async_rst_time", hh() * 10000 + mm() * 100 + ss(), 0);
    chk("async_rst_set", setting, 0);
    set_en = 0;
    cyc(1);
    rst_n = 1;
    cyc(TD - 1);
    chk("post_rst_no_tick", tick_1hz, 0);
    cyc(1);
    chk("post_rst_tick", tick_1hz, 1);

    // Randomized phase
    for (int i = 0; i < 4000; i++) begin
      rst_n = ($urandom_range(0, 499) != 0);
      if ($urandom_range(0, 29) == 0) set_en = ~set_en;
      inc_min = ($urandom_range(0, 3) == 0);
      inc_hr  = ($urandom_range(0, 5) == 0);
      cyc(1);
    end
    rst_n = 1; inc_min = 0; inc_hr = 0; set_en = 0;
    cyc(2);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
